// File: rtl/wb_sel_pkg.sv
// Shared types and constants for the write-back result selector.
// Source indices follow the RV32F datapath ordering.
package wb_sel_pkg;

    localparam int WB_WIDTH = 32;
    localparam int WB_NSRC  = 8;

    localparam int SRC_ALU   = 0;
    localparam int SRC_FADD  = 1;
    localparam int SRC_FMUL  = 2;
    localparam int SRC_FCVT  = 3;
    localparam int SRC_LOAD  = 4;
    localparam int SRC_PC4   = 5;
    localparam int SRC_FDIV  = 6;
    localparam int SRC_FSQRT = 7;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } wb_state_e;

endpackage

// File: rtl/wb_sel_watchdog.sv
// Wait-state cycle counter; flags expiry when a multi-cycle unit never
// answers. Only built when WB_SEL_TIMEOUT_EN is defined.
module wb_sel_watchdog #(
    parameter int TIMEOUT = 64
) (
    input  logic clk,
    input  logic rst_n,
    input  logic active,
    output logic expire
);

    localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    logic [CW-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (!active) begin
            count <= '0;
        end else begin
            count <= count + 1'b1;
        end
    end

    assign expire = active && (count == CW'(TIMEOUT - 1));

endmodule

// File: rtl/wb_result_sel.sv
// Registered write-back result selector with multi-cycle stall handling.
// Optional watchdog enabled by defining WB_SEL_TIMEOUT_EN.
module wb_result_sel
    import wb_sel_pkg::*;
#(
    parameter int WIDTH   = WB_WIDTH,
    parameter int NSRC    = WB_NSRC,
    parameter int SELW    = $clog2(NSRC),
    parameter int TIMEOUT = 64
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NSRC*WIDTH-1:0] src_data,
    input  logic [SELW-1:0]       sel,
    input  logic                  req_valid,
    input  logic [NSRC-1:0]       mc_mask,
    input  logic [NSRC-1:0]       src_done,
    input  logic                  flush,
    output logic [WIDTH-1:0]      out_data,
    output logic                  out_valid,
    output logic                  stall,
    output logic                  err
);

    wb_state_e       state;
    logic [SELW-1:0] sel_q;
    logic [WIDTH-1:0] pick_data;
    logic [WIDTH-1:0] wait_data;
    logic            pick_mc;
    logic            wait_done;
    logic            expire;

    // Out-of-range selects match no source: zero data, single-cycle.
    always_comb begin
        pick_data = '0;
        pick_mc   = 1'b0;
        wait_data = '0;
        wait_done = 1'b0;
        for (int i = 0; i < NSRC; i++) begin
            if (int'(sel) == i) begin
                pick_data = src_data[i*WIDTH +: WIDTH];
                pick_mc   = mc_mask[i];
            end
            if (int'(sel_q) == i) begin
                wait_data = src_data[i*WIDTH +: WIDTH];
                wait_done = src_done[i];
            end
        end
    end

`ifdef WB_SEL_TIMEOUT_EN
    wb_sel_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk    (clk),
        .rst_n  (rst_n),
        .active (state == WAIT),
        .expire (expire)
    );
`else
    assign expire = 1'b0;
`endif

    always_comb begin
        stall = 1'b0;
        if (rst_n && !flush) begin
            if (state == IDLE) begin
                stall = req_valid && pick_mc;
            end else begin
                stall = !wait_done && !expire;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            sel_q     <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
            err       <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            err       <= 1'b0;
            if (flush) begin
                state <= IDLE;
            end else begin
                unique case (state)
                    IDLE: begin
                        if (req_valid) begin
                            if (pick_mc) begin
                                sel_q <= sel;
                                state <= WAIT;
                            end else begin
                                out_data  <= pick_data;
                                out_valid <= 1'b1;
                            end
                        end
                    end
                    WAIT: begin
                        // A real completion wins over a same-cycle expiry.
                        if (wait_done) begin
                            out_data  <= wait_data;
                            out_valid <= 1'b1;
                            state     <= IDLE;
                        end else if (expire) begin
                            out_data  <= '0;
                            out_valid <= 1'b1;
                            err       <= 1'b1;
                            state     <= IDLE;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule
